// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared defaults, mode encodings and helpers for board_clock_ctrl
package board_pkg;

  localparam int DEF_DIV_1K    = 33333;
  localparam int DEF_DIV_200K  = 166;
  localparam int DEF_DEB_DELAY = 333333;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_e;

  // Bits needed to hold the values 0..max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Lowest-numbered pressed button wins; no press keeps the current mode.
  function automatic mode_e next_mode(input logic [3:0] btn, input mode_e cur);
    if (btn[0]) return MODE_0;
    if (btn[1]) return MODE_1;
    if (btn[2]) return MODE_2;
    if (btn[3]) return MODE_3;
    return cur;
  endfunction

endpackage

// File: rtl/board_clock_ctrl_if.sv
// rtl/board_clock_ctrl_if.sv - raw board switches in, clock enables and status out
interface board_clock_ctrl_if;
  logic       sw_step;
  logic       sw_step_en;
  logic       sw_power;
  logic [3:0] btn;
  logic       sys_reset;
  logic       step_enable;
  logic       game_tick;
  logic       cpu_clock;
  logic       clk_1k;
  logic       clk_200k;
  logic [1:0] mode;

  modport master (
    output sw_step, sw_step_en, sw_power, btn,
    input  sys_reset, step_enable, game_tick, cpu_clock, clk_1k, clk_200k, mode
  );

  modport slave (
    input  sw_step, sw_step_en, sw_power, btn,
    output sys_reset, step_enable, game_tick, cpu_clock, clk_1k, clk_200k, mode
  );
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - stable-count debouncer; output follows input after DELAY+2 quiet cycles
module switch_debounce
  import board_pkg::*;
#(
  parameter int DELAY = DEF_DEB_DELAY
) (
  input  logic core_clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_clean
);

  localparam int                CW        = cnt_width(DELAY);
  localparam logic [CW-1:0]     COUNT_MAX = CW'(DELAY);

  logic          r_last;
  logic          r_clean;
  logic [CW-1:0] r_count;

  // Reset adopts the present switch level so power-up never produces a fake edge.
  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_last  <= i_raw;
      r_clean <= i_raw;
      r_count <= '0;
    end else if (i_raw != r_last) begin
      r_last  <= i_raw;
      r_count <= '0;
    end else if (r_count == COUNT_MAX) begin
      r_clean <= r_last;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/board_clock_ctrl.sv
// rtl/board_clock_ctrl.sv - slow clock dividers, switch debouncing, game tick / cpu clock and debug mode
module board_clock_ctrl
  import board_pkg::*;
#(
  parameter int DIV_1K    = DEF_DIV_1K,
  parameter int DIV_200K  = DEF_DIV_200K,
  parameter int DEB_DELAY = DEF_DEB_DELAY
) (
  input  logic               core_clock,
  input  logic               reset,
  board_clock_ctrl_if.slave  bus
);

  localparam int                 W1K       = cnt_width(DIV_1K - 1);
  localparam int                 W200K     = cnt_width(DIV_200K - 1);
  localparam logic [W1K-1:0]     LAST_1K   = W1K'(DIV_1K - 1);
  localparam logic [W200K-1:0]   LAST_200K = W200K'(DIV_200K - 1);

  logic [W1K-1:0]   r_cnt_1k;
  logic [W200K-1:0] r_cnt_200k;
  logic             r_clk_1k;
  logic             r_clk_200k;
  logic             w_wrap_1k;
  logic             w_wrap_200k;

  logic             w_step_clean;
  logic             w_step_en_clean;
  logic             w_pwr_off_clean;
  logic [3:0]       w_btn_clean;

  logic             r_step_d;
  logic             w_step_rise;
  logic             w_game_tick;
  logic [2:0]       r_div;
  mode_e            r_mode;

  assign w_wrap_1k   = (r_cnt_1k == LAST_1K);
  assign w_wrap_200k = (r_cnt_200k == LAST_200K);

  // The slow "clocks" are plain registered levels toggled on each wrap.
  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_cnt_1k <= '0;
      r_clk_1k <= 1'b0;
    end else if (w_wrap_1k) begin
      r_cnt_1k <= '0;
      r_clk_1k <= ~r_clk_1k;
    end else begin
      r_cnt_1k <= r_cnt_1k + 1'b1;
    end
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_cnt_200k <= '0;
      r_clk_200k <= 1'b0;
    end else if (w_wrap_200k) begin
      r_cnt_200k <= '0;
      r_clk_200k <= ~r_clk_200k;
    end else begin
      r_cnt_200k <= r_cnt_200k + 1'b1;
    end
  end

  switch_debounce #(.DELAY(DEB_DELAY)) u_deb_step (
    .core_clock (core_clock),
    .reset      (reset),
    .i_raw      (bus.sw_step),
    .o_clean    (w_step_clean)
  );

  switch_debounce #(.DELAY(DEB_DELAY)) u_deb_step_en (
    .core_clock (core_clock),
    .reset      (reset),
    .i_raw      (bus.sw_step_en),
    .o_clean    (w_step_en_clean)
  );

  // Debounce the power-off sense so a clean 1 means "board is off".
  switch_debounce #(.DELAY(DEB_DELAY)) u_deb_pwr (
    .core_clock (core_clock),
    .reset      (reset),
    .i_raw      (~bus.sw_power),
    .o_clean    (w_pwr_off_clean)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn_deb
    switch_debounce #(.DELAY(DEB_DELAY)) u_deb_btn (
      .core_clock (core_clock),
      .reset      (reset),
      .i_raw      (bus.btn[gi]),
      .o_clean    (w_btn_clean[gi])
    );
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= w_step_clean;
    end
  end

  assign w_step_rise = w_step_clean & ~r_step_d;
  assign w_game_tick = ~w_step_en_clean | w_step_rise;

  // A step advances by half the divider range so cpu_clock flips once per step.
  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_div <= 3'd0;
    end else if (w_game_tick) begin
      r_div <= r_div + (w_step_en_clean ? 3'd4 : 3'd1);
    end
  end

  always_ff @(posedge core_clock) begin
    if (reset) begin
      r_mode <= MODE_0;
    end else begin
      r_mode <= next_mode(w_btn_clean, r_mode);
    end
  end

  assign bus.sys_reset   = reset | w_pwr_off_clean;
  assign bus.step_enable = w_step_en_clean;
  assign bus.game_tick   = w_game_tick;
  assign bus.cpu_clock   = r_div[2];
  assign bus.clk_1k      = r_clk_1k;
  assign bus.clk_200k    = r_clk_200k;
  assign bus.mode        = r_mode;

endmodule

// File: tb/tb_board_clock_ctrl.sv
// tb/tb_board_clock_ctrl.sv - directed self-checking bench for board_clock_ctrl
module tb_board_clock_ctrl;

  logic core_clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  board_clock_ctrl_if bif ();

  board_clock_ctrl #(
    .DIV_1K    (10),
    .DIV_200K  (4),
    .DEB_DELAY (3)
  ) dut (
    .core_clock (core_clock),
    .reset      (reset),
    .bus        (bif)
  );

  initial core_clock = 1'b0;
  always #5 core_clock = ~core_clock;

  // Leaves the bench at a falling edge with reset still high after two rising edges.
  task automatic apply_reset();
    @(negedge core_clock);
    reset = 1'b1;
    @(negedge core_clock);
    @(negedge core_clock);
  endtask

  task automatic test_reset();
    bif.sw_power   = 1'b1;
    bif.sw_step    = 1'b0;
    bif.sw_step_en = 1'b0;
    bif.btn        = 4'b0000;
    apply_reset();
    n_checks++;
    if (bif.clk_1k !== 1'b0) begin n_fail++; $display("FAIL reset_clk_1k: got %b expected 0", bif.clk_1k); end
    n_checks++;
    if (bif.clk_200k !== 1'b0) begin n_fail++; $display("FAIL reset_clk_200k: got %b expected 0", bif.clk_200k); end
    n_checks++;
    if (bif.cpu_clock !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_clock: got %b expected 0", bif.cpu_clock); end
    n_checks++;
    if (bif.mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", bif.mode); end
    n_checks++;
    if (bif.sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sys_reset: got %b expected 1", bif.sys_reset); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bif.sys_reset !== 1'b0) begin n_fail++; $display("FAIL release_sys_reset: got %b expected 0", bif.sys_reset); end
  endtask

  task automatic test_dividers();
    logic e200, e1k;
    for (int k = 1; k <= 12; k++) begin
      @(negedge core_clock);
      e200 = ((k / 4) % 2) == 1;
      e1k  = ((k / 10) % 2) == 1;
      n_checks++;
      if (bif.clk_200k !== e200) begin
        n_fail++; $display("FAIL div_clk_200k cycle %0d: got %b expected %b", k, bif.clk_200k, e200);
      end
      n_checks++;
      if (bif.clk_1k !== e1k) begin
        n_fail++; $display("FAIL div_clk_1k cycle %0d: got %b expected %b", k, bif.clk_1k, e1k);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic e200;
    repeat (2) @(negedge core_clock);
    apply_reset();
    n_checks++;
    if (bif.clk_1k !== 1'b0) begin n_fail++; $display("FAIL midreset_clk_1k: got %b expected 0", bif.clk_1k); end
    n_checks++;
    if (bif.clk_200k !== 1'b0) begin n_fail++; $display("FAIL midreset_clk_200k: got %b expected 0", bif.clk_200k); end
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge core_clock);
      e200 = (k >= 4);
      n_checks++;
      if (bif.clk_200k !== e200) begin
        n_fail++; $display("FAIL midreset_first_pulse cycle %0d: got %b expected %b", k, bif.clk_200k, e200);
      end
    end
  endtask

  task automatic test_power();
    logic exp_rst;
    bif.sw_power = 1'b0;
    apply_reset();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bif.sys_reset !== 1'b1) begin n_fail++; $display("FAIL power_off_after_reset: got %b expected 1", bif.sys_reset); end
    bif.sw_power = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge core_clock);
      exp_rst = (k < 5);
      n_checks++;
      if (bif.sys_reset !== exp_rst) begin
        n_fail++; $display("FAIL power_on_sys_reset cycle %0d: got %b expected %b", k, bif.sys_reset, exp_rst);
      end
    end
  endtask

  task automatic test_glitch();
    bif.sw_step    = 1'b0;
    bif.sw_step_en = 1'b1;
    repeat (8) @(negedge core_clock);
    n_checks++;
    if (bif.step_enable !== 1'b1) begin n_fail++; $display("FAIL step_enable_debounced: got %b expected 1", bif.step_enable); end
    bif.sw_step = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge core_clock);
      if (k == 1) bif.sw_step = 1'b0;
      n_checks++;
      if (bif.game_tick !== 1'b0) begin
        n_fail++; $display("FAIL glitch_game_tick cycle %0d: got %b expected 0", k, bif.game_tick);
      end
    end
  endtask

  task automatic test_free_run();
    logic [15:0] pattern;
    pattern        = 16'b0000111100001111;
    bif.sw_step    = 1'b0;
    bif.sw_step_en = 1'b0;
    apply_reset();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge core_clock);
      n_checks++;
      if (bif.cpu_clock !== pattern[15-k]) begin
        n_fail++; $display("FAIL free_cpu_clock cycle %0d: got %b expected %b", k, bif.cpu_clock, pattern[15-k]);
      end
      n_checks++;
      if (bif.game_tick !== 1'b1) begin
        n_fail++; $display("FAIL free_game_tick cycle %0d: got %b expected 1", k, bif.game_tick);
      end
    end
  endtask

  task automatic test_step();
    int   ticks;
    int   toggles;
    logic prev_tick;
    logic prev_cpu;
    bif.sw_step    = 1'b0;
    bif.sw_step_en = 1'b1;
    apply_reset();
    reset = 1'b0;
    #1;
    ticks     = 0;
    toggles   = 0;
    prev_tick = bif.game_tick;
    prev_cpu  = bif.cpu_clock;
    n_checks++;
    if (prev_tick !== 1'b0) begin n_fail++; $display("FAIL step_idle_tick: got %b expected 0", prev_tick); end
    for (int s = 0; s < 52; s++) begin
      @(negedge core_clock);
      bif.sw_step = (s < 48) && ((s % 16) < 8);
      if (bif.game_tick === 1'b1) ticks++;
      if (bif.cpu_clock !== prev_cpu) toggles++;
      n_checks++;
      if (prev_tick === 1'b1 && bif.game_tick === 1'b1) begin
        n_fail++; $display("FAIL step_tick_width sample %0d: got 2-cycle tick expected 1-cycle", s);
      end
      n_checks++;
      if ((bif.cpu_clock !== prev_cpu) !== (prev_tick === 1'b1)) begin
        n_fail++; $display("FAIL step_cpu_toggle sample %0d: got cpu %b->%b expected toggle only after tick (prev tick %b)",
                           s, prev_cpu, bif.cpu_clock, prev_tick);
      end
      prev_tick = bif.game_tick;
      prev_cpu  = bif.cpu_clock;
    end
    n_checks++;
    if (ticks != 3) begin n_fail++; $display("FAIL step_tick_count: got %0d expected 3", ticks); end
    n_checks++;
    if (toggles != 3) begin n_fail++; $display("FAIL step_cpu_toggles: got %0d expected 3", toggles); end
    n_checks++;
    if (bif.cpu_clock !== 1'b1) begin n_fail++; $display("FAIL step_cpu_final: got %b expected 1", bif.cpu_clock); end
  endtask

  task automatic test_mode();
    logic [3:0] btn_vec  [5];
    logic [1:0] mode_exp [5];
    btn_vec  = '{4'b0110, 4'b0000, 4'b1000, 4'b0100, 4'b0001};
    mode_exp = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd0};
    for (int i = 0; i < 5; i++) begin
      bif.btn = btn_vec[i];
      repeat (8) @(negedge core_clock);
      n_checks++;
      if (bif.mode !== mode_exp[i]) begin
        n_fail++; $display("FAIL mode btn=%b: got %0d expected %0d", btn_vec[i], bif.mode, mode_exp[i]);
      end
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bif.sw_step    = 1'b0;
    bif.sw_step_en = 1'b0;
    bif.sw_power   = 1'b1;
    bif.btn        = 4'b0000;
    test_reset();
    test_dividers();
    test_reset_midcount();
    test_power();
    test_glitch();
    test_free_run();
    test_step();
    test_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_clock_ctrl.md
BOARD_CLOCK_CTRL -- requirements
Module: board_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV_1K, default 33333: core_clock cycles per 1 kHz pulse.
REQ-002 SHALL have parameter DIV_200K, default 166: core_clock cycles per 200 kHz pulse.
REQ-003 SHALL have parameter DEB_DELAY, default 333333: debounce stable-count target.
REQ-004 SHALL have port core_clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port sw_step, input, 1 bit: raw single-step switch.
REQ-007 SHALL have port sw_step_en, input, 1 bit: raw step-mode enable switch.
REQ-008 SHALL have port sw_power, input, 1 bit: raw power switch; 0 = off.
REQ-009 SHALL have port btn, input, 4 bits: raw debug-mode buttons.
REQ-010 SHALL have port sys_reset, output, 1 bit: reset OR debounced power-off.
REQ-011 SHALL have port step_enable, output, 1 bit: debounced sw_step_en.
REQ-012 SHALL have port game_tick, output, 1 bit: one-cycle game-clock enable.
REQ-013 SHALL have port cpu_clock, output, 1 bit: divider bit 2.
REQ-014 SHALL have port clk_1k, output, 1 bit: toggling slow clock.
REQ-015 SHALL have port clk_200k, output, 1 bit: toggling slow clock.
REQ-016 SHALL have port mode, output, 2 bits: debug display mode.

Function
REQ-017 Pulse divider SHALL count 0..N-1 and assert a one-cycle pulse when the count wraps from N-1 to 0; N = DIV_1K or DIV_200K.
REQ-018 clk_1k / clk_200k SHALL toggle on each respective pulse, giving a period of 2*N cycles.
REQ-019 Each debouncer SHALL sample its raw input into "last"; when raw != last: last <= raw, count <= 0.
REQ-020 Each debouncer, when raw == last and count == DEB_DELAY, SHALL set clean <= last; otherwise count SHALL increment.
REQ-021 A stable input change SHALL therefore appear on clean DEB_DELAY+2 cycles after the raw edge.
REQ-022 Debouncers SHALL exist for sw_step, sw_step_en, inverted sw_power, and btn[3:0].
REQ-023 sys_reset SHALL equal combinational reset OR debounced !sw_power.
REQ-024 With step_enable=0, game_tick SHALL be 1 every cycle.
REQ-025 With step_enable=1, game_tick SHALL be 1 for exactly one cycle per rising edge of debounced sw_step (registered edge detect, 1-cycle latency).
REQ-026 On each game_tick, the 3-bit divider SHALL add 1 when step_enable=0 and 4 when step_enable=1, wrapping mod 8.
REQ-027 cpu_clock SHALL equal divider[2]: a period of 8 ticks normally and a toggle on every step.
REQ-028 mode SHALL update on debounced buttons with priority btn[0]->0, btn[1]->1, btn[2]->2, btn[3]->3, and SHALL hold when no button is pressed.

Reset
REQ-029 On reset, divider counters, clk_1k, clk_200k, the cpu divider, mode and the edge-detect register SHALL clear to 0.
REQ-030 On reset, each debouncer SHALL load last and clean with the current raw value and clear its count.
REQ-031 Reset mid-count SHALL restart every divider from 0, with the first pulse N cycles after reset deasserts.

Structure
REQ-032 Divider and debounce defaults plus mode encodings SHALL live in the shared package board_pkg.
REQ-033 The debouncer SHALL be the single sub-module switch_debounce (parameter DELAY), instantiated 7 times.
REQ-034 The block SHALL contain no vendor clock primitives and no derived clocks; all outputs SHALL be registered levels or enables in the core_clock domain.

Verification (DIV_1K=10, DIV_200K=4, DEB_DELAY=3)
REQ-035 Release reset -> clk_200k toggles after cycles 4, 8, 12; clk_1k toggles after cycle 10.
REQ-036 sw_power=0 held -> sys_reset=1 immediately after reset; sw_power rises -> sys_reset falls 5 cycles later.
REQ-037 sw_step glitch for 2 cycles -> no change in the debounced output and no game_tick.
REQ-038 step_enable=0 for 16 cycles -> cpu_clock shows 0000111100001111.
REQ-039 step_enable=1 with 3 clean sw_step presses -> exactly 3 single-cycle game_ticks; cpu_clock toggles on each.
REQ-040 btn=4'b0110 held -> mode=1; then btn=0 -> mode stays 1; then btn=4'b1000 -> mode=3.
